// File: rtl/demux_gate_pipe.sv
// Pipelined universal 2-input logic unit: per-bit truth-table lookup with BITWISE
// and packet-folding REDUCE modes, results buffered in a small output FIFO.
module demux_gate_pipe #(
    parameter int WIDTH      = 8,
    parameter int CNT_W      = 8,
    parameter int OBUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    input  logic [3:0]       cfg_tt,
    input  logic             cfg_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_sat
);
    // Handshake: a beat moves on in_valid & in_ready, a result on out_valid & out_ready;
    // out_* hold stable while out_valid is high and out_ready is low.
    localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int CW    = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACC  = 1'b1;

    function automatic logic [WIDTH-1:0] eval_tt(input logic [3:0] tt,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] y;
        y = '0;
        for (int i = 0; i < WIDTH; i++) begin
            y[i] = tt[{x[i], b[i]}];
        end
        return y;
    endfunction

    logic [0:0]       state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sat_q, sat_nxt;
    logic [3:0]       tt_q, tt_nxt;
    logic             in_ready_r;

    logic [WIDTH-1:0] mem_data  [OBUF_DEPTH];
    logic [CNT_W-1:0] mem_beats [OBUF_DEPTH];
    logic             mem_sat   [OBUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]    count, count_nxt;

    logic             accept, pop, push, clip;
    logic [3:0]       cur_tt;
    logic [WIDTH-1:0] f_res, push_data;
    logic [CNT_W-1:0] cnt_inc, push_beats;
    logic             push_sat;

    assign in_ready  = in_ready_r;
    assign out_valid = (count != '0);
    assign accept    = in_valid & in_ready_r;
    assign pop       = out_valid & out_ready;
    // Config is live only on the first beat; inside a packet the captured table rules.
    assign cur_tt    = (state == S_IDLE) ? cfg_tt : tt_q;
    assign f_res     = eval_tt(cur_tt, (state == S_IDLE) ? in_a : acc, in_b);
    assign clip      = (cnt == CNT_MAX);
    assign cnt_inc   = clip ? cnt : cnt + CNT_W'(1);

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        sat_nxt    = sat_q;
        tt_nxt     = tt_q;
        push       = 1'b0;
        push_data  = f_res;
        push_beats = CNT_W'(1);
        push_sat   = 1'b0;
        if (accept) begin
            if (state == S_IDLE) begin
                if (!cfg_mode || in_last) begin
                    push = 1'b1;
                end else begin
                    state_nxt = S_ACC;
                    acc_nxt   = f_res;
                    cnt_nxt   = CNT_W'(1);
                    sat_nxt   = 1'b0;
                    tt_nxt    = cfg_tt;
                end
            end else if (in_last) begin
                push       = 1'b1;
                push_beats = cnt_inc;
                push_sat   = sat_q | clip;
                state_nxt  = S_IDLE;
                acc_nxt    = '0;
                cnt_nxt    = '0;
                sat_nxt    = 1'b0;
            end else begin
                acc_nxt = f_res;
                cnt_nxt = cnt_inc;
                sat_nxt = sat_q | clip;
            end
        end
    end

    assign count_nxt = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            acc        <= '0;
            cnt        <= '0;
            sat_q      <= 1'b0;
            tt_q       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_ready_r <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            cnt        <= cnt_nxt;
            sat_q      <= sat_nxt;
            tt_q       <= tt_nxt;
            count      <= count_nxt;
            in_ready_r <= (count_nxt != CW'(OBUF_DEPTH));
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr]  <= push_data;
            mem_beats[wr_ptr] <= push_beats;
            mem_sat[wr_ptr]   <= push_sat;
        end
    end

    // Gate with out_valid so an empty buffer always presents zeros.
    assign out_data  = out_valid ? mem_data[rd_ptr]  : '0;
    assign out_beats = out_valid ? mem_beats[rd_ptr] : '0;
    assign out_sat   = out_valid ? mem_sat[rd_ptr]   : 1'b0;
endmodule
